button_debouncer: RTL and testbench

//   Conditions raw push-button pins before they reach the button PIO input port.
//   Per channel: 2-FF synchroniser, polarity normalisation, counter-based debounce.

---
 rtl/button_debouncer.sv | 107 ++++++++++
 tb/tb_button_debouncer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: conditions raw push-button pins for the button PIO.
// Each channel is synchronised, polarity-normalised (1 = pressed) and
// debounced by a counter; a change on the synchronised level is accepted
// only after CNT_MAX consecutive cycles of disagreement with btn_out.
// Press/release strobes are registered alongside btn_out so they mark the
// first cycle of the new level.
module button_debouncer #(
    parameter int WIDTH      = 2,
    parameter int CNT_MAX    = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int               CW       = $clog2(CNT_MAX);
    localparam logic [CW-1:0]    CNT_LAST = CW'(CNT_MAX - 1);
    localparam logic [WIDTH-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t          state_q [WIDTH];
    state_t          state_d [WIDTH];
    logic [CW-1:0]   cnt_q   [WIDTH];
    logic [CW-1:0]   cnt_d   [WIDTH];

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] press_d;
    logic [WIDTH-1:0] release_d;

    // Two-stage synchroniser; reset loads the released level so a held key
    // cannot produce a press until it has been debounced afresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw ^ POL_MASK;
            s2 <= s1;
        end
    end

    // Per-channel state, counter, debounced level and strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            btn_out       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            btn_out       <= out_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    // Next-state logic: count consecutive disagreement, accept on the last one.
    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            out_d[i]     = btn_out[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (s2[i] != btn_out[i]) begin
                        state_d[i] = CHECK;
                        cnt_d[i]   = CW'(1);
                    end
                end
                CHECK: begin
                    if (s2[i] == btn_out[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = IDLE;
                        cnt_d[i]     = '0;
                        out_d[i]     = s2[i];
                        press_d[i]   = s2[i];
                        release_d[i] = ~s2[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scoreboard bench for button_debouncer (CNT_MAX=4).
// A behavioural model predicts the outputs after every clock edge; the
// prediction is queued when the inputs are driven and compared after the edge.
module tb_button_debouncer;

    localparam int W   = 2;
    localparam int CNT = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] btn_raw = 2'b11;
    logic [W-1:0] btn_out;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;

    typedef struct packed {
        logic [W-1:0] o;
        logic [W-1:0] p;
        logic [W-1:0] r;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    // Model state: normalised pipeline, debounced level, consecutive-mismatch run.
    logic [W-1:0] m_p1 = '0;
    logic [W-1:0] m_p2 = '0;
    logic [W-1:0] m_out = '0;
    int           m_run [W];

    logic [W-1:0] obs_o, obs_p, obs_r;

    button_debouncer #(
        .WIDTH     (W),
        .CNT_MAX   (CNT),
        .ACTIVE_LOW(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_out      (btn_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict, advance one edge, compare.
    task automatic tick(input logic [W-1:0] raw_v, input logic rst_v);
        exp_t e;
        btn_raw = raw_v;
        reset   = rst_v;
        e.p = '0;
        e.r = '0;
        if (rst_v) begin
            m_p1  = '0;
            m_p2  = '0;
            m_out = '0;
            for (int c = 0; c < W; c++) m_run[c] = 0;
        end else begin
            for (int c = 0; c < W; c++) begin
                if (m_p2[c] != m_out[c]) begin
                    m_run[c]++;
                    if (m_run[c] == CNT) begin
                        m_out[c] = ~m_out[c];
                        if (m_out[c]) e.p[c] = 1'b1;
                        else          e.r[c] = 1'b1;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_p2 = m_p1;
            m_p1 = ~raw_v;
        end
        e.o = m_out;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        obs_o = btn_out;
        obs_p = press_pulse;
        obs_r = release_pulse;
        if (sbq.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check("btn_out", 32'(obs_o), 32'(e.o));
            check("press", 32'(obs_p), 32'(e.p));
            check("release", 32'(obs_r), 32'(e.r));
            check("excl", 32'(obs_p & obs_r), 32'd0);
        end
    endtask

    // Run up to 12 ticks at a fixed input; return the first tick index at which
    // the selected strobe equals mask (0 if never).
    task automatic measure(input logic [W-1:0] raw_v, input logic use_press,
                           input logic [W-1:0] mask, output int lat, output int other);
        lat   = 0;
        other = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(raw_v, 1'b0);
            if (lat == 0 && ((use_press ? obs_p : obs_r) == mask)) lat = k;
            if ((use_press ? obs_r : obs_p) != '0) other++;
        end
    endtask

    int lat, other, cnt_p;

    initial begin
        for (int c = 0; c < W; c++) m_run[c] = 0;

        // 1: reset with both keys held, then release reset.
        for (int k = 0; k < 3; k++) tick(2'b00, 1'b1);
        check("t1_rst_out", 32'(obs_o), 32'd0);
        measure(2'b00, 1'b1, 2'b11, lat, other);
        check("t1_lat", 32'(lat), 32'd6);
        check("t1_out", 32'(obs_o), 32'h3);

        // 2: release both, then press channel 0 only.
        for (int k = 0; k < 10; k++) tick(2'b11, 1'b0);
        check("t2_idle", 32'(obs_o), 32'd0);
        measure(2'b10, 1'b1, 2'b01, lat, other);
        check("t2_lat", 32'(lat), 32'd6);
        check("t2_out", 32'(obs_o), 32'h1);

        // 3: bounce ch0 (3 low, 1 high) ten times, then hold low.
        for (int k = 0; k < 10; k++) tick(2'b11, 1'b0);
        cnt_p = 0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 3; k++) begin
                tick(2'b10, 1'b0);
                if (obs_p != '0 || obs_r != '0) cnt_p++;
            end
            tick(2'b11, 1'b0);
            if (obs_p != '0 || obs_r != '0) cnt_p++;
        end
        check("t3_nopulse", 32'(cnt_p), 32'd0);
        check("t3_out", 32'(obs_o), 32'd0);
        measure(2'b10, 1'b1, 2'b01, lat, other);
        check("t3_lat", 32'(lat), 32'd6);

        // 4: release channel 0.
        measure(2'b11, 1'b0, 2'b01, lat, other);
        check("t4_lat", 32'(lat), 32'd6);
        check("t4_nopress", 32'(other), 32'd0);
        check("t4_out", 32'(obs_o), 32'd0);

        // 5: both fall together.
        measure(2'b00, 1'b1, 2'b11, lat, other);
        check("t5_lat", 32'(lat), 32'd6);
        check("t5_out", 32'(obs_o), 32'h3);

        // 6: reset at count=2 of a press, then full re-debounce.
        for (int k = 0; k < 10; k++) tick(2'b11, 1'b0);
        for (int k = 0; k < 4; k++) tick(2'b00, 1'b0);
        check("t6_pre", 32'(obs_o), 32'd0);
        tick(2'b00, 1'b1);
        check("t6_rst", 32'(obs_o | obs_p), 32'd0);
        measure(2'b00, 1'b1, 2'b11, lat, other);
        check("t6_lat", 32'(lat), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
